// File: rtl/dffnsnq_bank_set_sequencer_if.sv
// Request/handshake bundle between the bank requesters and the shared
// async-set sequencer; the master side drives requests and counts.
interface dffnsnq_bank_set_sequencer_if #(
  parameter int NBANK = 4,
  parameter int CW    = 4
);
  logic [NBANK-1:0] REQ;
  logic [CW-1:0]    PULSE_CYC;
  logic [CW-1:0]    REC_CYC;
  logic [NBANK-1:0] SETN_O;
  logic [NBANK-1:0] CKEN_O;
  logic [NBANK-1:0] ACK;
  logic             BUSY;

  modport master (
    output REQ, PULSE_CYC, REC_CYC,
    input  SETN_O, CKEN_O, ACK, BUSY
  );

  modport slave (
    input  REQ, PULSE_CYC, REC_CYC,
    output SETN_O, CKEN_O, ACK, BUSY
  );
endinterface

// File: rtl/dffnsnq_bank_set_sequencer.sv
// Shared async-set sequencer: gates a bank clock, pulses its SETN low for a
// latched width, holds the clock off for recovery, then restores and acks.
module dffnsnq_bank_set_sequencer #(
  parameter int NBANK = 4,
  parameter int CW    = 4
) (
  input logic                         CLK,
  input logic                         RN,
  dffnsnq_bank_set_sequencer_if.slave bus
);

  localparam int GW = (NBANK > 1) ? $clog2(NBANK) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATE,
    S_ASSERT,
    S_RECOVER,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [GW-1:0]    r_grant;
  logic [GW-1:0]    r_ptr;
  logic [CW-1:0]    r_plen;
  logic [CW-1:0]    r_rlen;
  logic [CW-1:0]    r_cnt;
  logic [NBANK-1:0] r_setn;
  logic [NBANK-1:0] r_cken;
  logic [NBANK-1:0] r_ack;
  logic             r_busy;

  state_t           w_state_nxt;
  logic [GW-1:0]    w_grant_nxt;
  logic [GW-1:0]    w_ptr_nxt;
  logic [CW-1:0]    w_plen_nxt;
  logic [CW-1:0]    w_rlen_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [NBANK-1:0] w_onehot;
  logic [NBANK-1:0] w_setn_nxt;
  logic [NBANK-1:0] w_cken_nxt;
  logic [NBANK-1:0] w_ack_nxt;
  logic             w_busy_nxt;
  logic             w_hit;
  logic [GW-1:0]    w_sel;
  logic [GW-1:0]    w_idx;

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    w_idx = '0;
    for (int i = 0; i < NBANK; i++) begin
      w_idx = GW'((int'(r_ptr) + i) % NBANK);
      if (!w_hit && bus.REQ[w_idx]) begin
        w_hit = 1'b1;
        w_sel = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_plen_nxt  = r_plen;
    w_rlen_nxt  = r_rlen;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          w_state_nxt = S_GATE;
          w_grant_nxt = w_sel;
          w_plen_nxt  = (bus.PULSE_CYC == '0) ? CW'(1) : bus.PULSE_CYC;
          w_rlen_nxt  = (bus.REC_CYC == '0) ? CW'(1) : bus.REC_CYC;
          w_cnt_nxt   = '0;
        end
      end
      S_GATE: begin
        w_state_nxt = S_ASSERT;
        w_cnt_nxt   = CW'(1);
      end
      S_ASSERT: begin
        if (r_cnt >= r_plen) begin
          w_state_nxt = S_RECOVER;
          w_cnt_nxt   = CW'(1);
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_RECOVER: begin
        if (r_cnt >= r_rlen) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_ptr_nxt   = (r_grant == GW'(NBANK - 1)) ? '0 : r_grant + GW'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes off a flop.
  assign w_onehot = NBANK'(1) << w_grant_nxt;

  always_comb begin
    w_setn_nxt = '1;
    w_cken_nxt = '1;
    w_ack_nxt  = '0;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    case (w_state_nxt)
      S_GATE:    w_cken_nxt = ~w_onehot;
      S_ASSERT: begin
        w_cken_nxt = ~w_onehot;
        w_setn_nxt = ~w_onehot;
      end
      S_RECOVER: w_cken_nxt = ~w_onehot;
      S_DONE:    w_ack_nxt  = w_onehot;
      default:   w_busy_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_plen  <= '0;
      r_rlen  <= '0;
      r_cnt   <= '0;
      r_setn  <= '1;
      r_cken  <= '1;
      r_ack   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
      r_plen  <= w_plen_nxt;
      r_rlen  <= w_rlen_nxt;
      r_cnt   <= w_cnt_nxt;
      r_setn  <= w_setn_nxt;
      r_cken  <= w_cken_nxt;
      r_ack   <= w_ack_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign bus.SETN_O = r_setn;
  assign bus.CKEN_O = r_cken;
  assign bus.ACK    = r_ack;
  assign bus.BUSY   = r_busy;

endmodule

// File: tb/tb_dffnsnq_bank_set_sequencer.sv
// Bench for the bank set sequencer: a timeline model (grant edge, bank, P, R)
// predicts every output each cycle; directed scenarios plus random traffic.
module tb_dffnsnq_bank_set_sequencer;
  localparam int NBANK = 4;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic rn  = 1'b1;
  always #5 clk = ~clk;

  dffnsnq_bank_set_sequencer_if #(.NBANK(NBANK), .CW(CW)) bus ();
  dffnsnq_bank_set_sequencer #(.NBANK(NBANK), .CW(CW)) dut (
    .CLK (clk),
    .RN  (rn),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: one active sequence, k = edges elapsed since its grant edge.
  bit m_act;
  int m_k, m_g, m_p, m_r, m_ptr;

  int cyc = 0;
  int q_ack[$];
  int q_cyc[$];
  int setn_low[NBANK];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_act = 1'b0;
    m_k   = 0;
    m_ptr = 0;
  endfunction

  function automatic void model_step();
    bit found;
    int b;
    if (!m_act) begin
      found = 1'b0;
      for (int i = 0; i < NBANK; i++) begin
        b = (m_ptr + i) % NBANK;
        if (!found && bus.REQ[b]) begin
          found = 1'b1;
          m_g   = b;
        end
      end
      if (found) begin
        m_act = 1'b1;
        m_k   = 0;
        m_p   = (bus.PULSE_CYC == 0) ? 1 : int'(bus.PULSE_CYC);
        m_r   = (bus.REC_CYC == 0) ? 1 : int'(bus.REC_CYC);
      end
    end else begin
      m_k++;
      if (m_k == m_p + m_r + 2) begin
        m_act = 1'b0;
        m_ptr = (m_g + 1) % NBANK;
      end
    end
  endfunction

  task automatic compare_all(input string tag);
    logic [NBANK-1:0] e_setn, e_cken, e_ack;
    logic             e_busy;
    e_setn = '1;
    e_cken = '1;
    e_ack  = '0;
    e_busy = 1'b0;
    if (m_act) begin
      e_busy = 1'b1;
      if (m_k <= m_p + m_r)             e_cken[m_g] = 1'b0;
      if (m_k >= 1 && m_k <= m_p)       e_setn[m_g] = 1'b0;
      if (m_k == m_p + m_r + 1)         e_ack[m_g]  = 1'b1;
    end
    check_eq({tag, "_setn"}, 32'(bus.SETN_O), 32'(e_setn));
    check_eq({tag, "_cken"}, 32'(bus.CKEN_O), 32'(e_cken));
    check_eq({tag, "_ack"},  32'(bus.ACK),    32'(e_ack));
    check_eq({tag, "_busy"}, 32'(bus.BUSY),   32'(e_busy));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    cyc++;
    if (rn) model_step();
    else    model_reset();
    #1;
    compare_all(tag);
    for (int b = 0; b < NBANK; b++) begin
      if (bus.ACK[b]) begin
        q_ack.push_back(b);
        q_cyc.push_back(cyc);
      end
      if (!bus.SETN_O[b]) setn_low[b]++;
    end
  endtask

  task automatic clear_logs();
    q_ack.delete();
    q_cyc.delete();
    for (int b = 0; b < NBANK; b++) setn_low[b] = 0;
  endtask

  // Called at posedge+1: reset lands mid-cycle, outputs must clear before the next edge.
  task automatic async_reset_pulse(input string tag);
    #1;
    rn = 1'b0;
    #1;
    model_reset();
    compare_all({tag, "_async"});
    tick({tag, "_rstlow"});
    rn = 1'b1;
  endtask

  task automatic wait_ack(input int bank, input int budget, input bit drop, input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      tick(tag);
      if (bus.ACK[bank]) begin
        seen = 1'b1;
        if (drop) bus.REQ[bank] = 1'b0;
      end
    end
    check_eq({tag, "_ack_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_model_k(input int k, input int budget, input string tag);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      tick(tag);
      if (m_act && m_k == k) hit = 1'b1;
    end
    check_eq({tag, "_reached"}, 32'(hit), 32'd1);
  endtask

  initial begin
    int rr_exp[5];
    int budget;
    rr_exp = '{0, 1, 2, 3, 0};
    bus.REQ       = '0;
    bus.PULSE_CYC = '0;
    bus.REC_CYC   = '0;
    model_reset();

    // Reset with random requests present.
    #2;
    rn = 1'b0;
    bus.REQ = NBANK'($urandom);
    #1;
    compare_all("rst");
    repeat (3) tick("rst_hold");
    bus.REQ = '0;
    rn = 1'b1;
    repeat (20) tick("idle");

    // Single request P=3 R=2 on bank 2.
    clear_logs();
    bus.PULSE_CYC = 4'd3;
    bus.REC_CYC   = 4'd2;
    bus.REQ       = 4'b0100;
    wait_ack(2, 20, 1'b1, "single");
    repeat (4) tick("single_tail");
    check_eq("single_setn_width", 32'(setn_low[2]), 32'd3);

    // Zero counts act as one; ACKs spaced by 5 cycles.
    clear_logs();
    bus.PULSE_CYC = 4'd0;
    bus.REC_CYC   = 4'd0;
    bus.REQ       = 4'b0001;
    repeat (17) tick("zero");
    bus.REQ = '0;
    repeat (8) tick("zero_tail");
    check_eq("zero_nack", 32'(q_cyc.size() >= 3), 32'd1);
    if (q_cyc.size() >= 3) begin
      check_eq("zero_spacing01", 32'(q_cyc[1] - q_cyc[0]), 32'd5);
      check_eq("zero_spacing12", 32'(q_cyc[2] - q_cyc[1]), 32'd5);
      check_eq("zero_setn_width", 32'(setn_low[0]), 32'(q_cyc.size()));
    end

    // Round-robin from pointer 0 with all banks requesting.
    async_reset_pulse("rr_pre");
    clear_logs();
    bus.PULSE_CYC = 4'd1;
    bus.REC_CYC   = 4'd1;
    bus.REQ       = 4'b1111;
    budget = 80;
    while (q_ack.size() < 5 && budget > 0) begin
      tick("rr");
      budget--;
    end
    bus.REQ = '0;
    repeat (8) tick("rr_tail");
    check_eq("rr_count", 32'(q_ack.size()), 32'd5);
    for (int i = 0; i < 5 && i < q_ack.size(); i++)
      check_eq($sformatf("rr_order%0d", i), 32'(q_ack[i]), 32'(rr_exp[i]));

    // Serve bank 1 so the pointer sits at 2, then request banks 0 and 1.
    bus.REQ = 4'b0010;
    wait_ack(1, 20, 1'b1, "ptr2_setup");
    repeat (2) tick("ptr2_gap");
    clear_logs();
    bus.REQ = 4'b0011;
    wait_ack(0, 20, 1'b1, "ptr2_first");
    wait_ack(1, 20, 1'b1, "ptr2_second");
    check_eq("ptr2_count", 32'(q_ack.size()), 32'd2);
    if (q_ack.size() == 2) begin
      check_eq("ptr2_order0", 32'(q_ack[0]), 32'd0);
      check_eq("ptr2_order1", 32'(q_ack[1]), 32'd1);
    end
    repeat (3) tick("ptr2_tail");

    // Mid-sequence: drop REQ and change PULSE_CYC during ASSERT.
    clear_logs();
    bus.PULSE_CYC = 4'd2;
    bus.REC_CYC   = 4'd3;
    bus.REQ       = 4'b0010;
    wait_model_k(1, 20, "mid_pre");
    bus.REQ       = 4'b0000;
    bus.PULSE_CYC = 4'd9;
    wait_ack(1, 20, 1'b0, "mid");
    repeat (3) tick("mid_tail");
    check_eq("mid_setn_width", 32'(setn_low[1]), 32'd2);

    // Async reset while SETN_O[3] is low, then a fresh sequence.
    bus.PULSE_CYC = 4'd5;
    bus.REC_CYC   = 4'd2;
    bus.REQ       = 4'b1000;
    wait_model_k(2, 20, "ar_pre");
    check_eq("ar_setn_low", 32'(bus.SETN_O[3]), 32'd0);
    async_reset_pulse("ar");
    clear_logs();
    wait_ack(3, 30, 1'b1, "ar_fresh");
    check_eq("ar_fresh_setn_width", 32'(setn_low[3]), 32'd5);
    repeat (3) tick("ar_tail");

    // Random traffic with handshake-style requesters.
    bus.REQ = '0;
    for (int n = 0; n < 2500; n++) begin
      for (int b = 0; b < NBANK; b++) begin
        if (!bus.REQ[b]) begin
          if ($urandom_range(3) == 0) bus.REQ[b] = 1'b1;
        end else if (bus.ACK[b]) begin
          if ($urandom_range(1) == 0) bus.REQ[b] = 1'b0;
        end else if ($urandom_range(39) == 0) begin
          bus.REQ[b] = 1'b0;
        end
      end
      bus.PULSE_CYC = ($urandom_range(9) == 0) ? 4'd15 : CW'($urandom_range(5));
      bus.REC_CYC   = ($urandom_range(9) == 0) ? 4'd15 : CW'($urandom_range(5));
      if ($urandom_range(299) == 0) async_reset_pulse("rnd");
      else                          tick("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
